axi_rd_arbiter: RTL
===================

Name: axi_rd_arbiter

Overview:
- Owns the AXI read-address (AR) and read-data (R) channels.
- Arbitrates single-beat reads between the instruction-fetch SRAM-like port and the data-load SRAM-like port, tracking outstanding reads per requester by ARID.
- Blocks a data read whose word address matches a write still in flight on the write path (read-after-write hazard).
- Sits between the IF/EX/MEM stages and the AXI interconnect.

Parameters:
- MAX_OUTST, 2, maximum outstanding reads per requester (1..7).
- STARVE_LIMIT, 4, consecutive data grants allowed while inst waits before inst is forced to win.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- inst_req  in  1  fetch read request, held until inst_addr_ok
- inst_addr  in  32  fetch address
- inst_size  in  2  log2 bytes
- inst_addr_ok  out  1  fetch request accepted on AR
- inst_data_ok  out  1  fetch data valid
- inst_rdata  out  32  fetch data
- data_req  in  1  load read request, held until data_addr_ok
- data_addr  in  32  load address
- data_size  in  2  log2 bytes
- data_addr_ok  out  1  load request accepted on AR
- data_data_ok  out  1  load data valid
- data_rdata  out  32  load data
- wr_pending  in  1  write path has an un-responded write
- wr_pending_addr  in  32  address of that write
- arid  out  4  0 = inst, 1 = data
- araddr  out  32  latched address
- arsize  out  3  {1'b0, size}
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  R id
- rdata  in  32  R data
- rvalid  in  1  R valid
- rready  out  1  R ready

Behaviour:
- Clock aclk; reset aresetn, asynchronous, active-low. During reset: arvalid=0, rready=0, arid=0, araddr=0, arsize=0, FSM=AR_IDLE, both counters=0, starve counter=0.
- rready is registered and reads 1 from the first cycle after reset release.
- AR_IDLE: grant is evaluated each cycle.
  - data_ok_to_go = data_req && data_cnt<MAX_OUTST && !(wr_pending && wr_pending_addr[31:2]==data_addr[31:2]).
  - inst_ok_to_go = inst_req && inst_cnt<MAX_OUTST.
  - Data wins, unless inst_ok_to_go && starve_cnt==STARVE_LIMIT, in which case inst wins.
  - On grant: latch arid/araddr/arsize from the winner; arvalid<=1; go to AR_BUSY. Latency from req to arvalid is 1 cycle.
- AR_BUSY: arvalid, araddr, arid and arsize are held stable until arready.
  - On arvalid&&arready: arvalid<=0, return to AR_IDLE (no back-to-back grant in the same cycle).
  - Pulse {inst|data}_addr_ok combinationally in that cycle, selected by arid.
- starve_cnt:
  - +1 (saturating at STARVE_LIMIT) on each data AR handshake while inst_req=1.
  - Cleared on an inst AR handshake, or when inst_req=0.
- Counters:
  - cnt[id] +1 on an AR handshake with that id.
  - cnt[id] -1 on rvalid&&rready with that rid.
  - Increment and decrement in the same cycle leave the count unchanged.
  - Decrement at 0 saturates at 0 (assertion fires).
- R channel:
  - inst_data_ok = rvalid&&rready&&rid==0; data_data_ok = rvalid&&rready&&rid==1. Both are combinational, same cycle as R.
  - inst_rdata = data_rdata = rdata.
  - rresp is ignored. rid>1 is dropped with no data_ok (assertion fires).
- Hazard: the RAW check is combinational every AR_IDLE cycle. A blocked data request does not stall an eligible inst request.
- Counter full (cnt==MAX_OUTST): that requester is not granted; the other is still eligible.
- Reset mid-transaction: all state clears asynchronously. Outstanding R beats returning after release are treated as unexpected (counter at 0 saturates).
- AR beats are fixed: single beat. arlen, arburst and related fields are driven as constants outside this block.

Decomposition:
- Shared package axi_pkg:
  - ARID_INST=4'd0, ARID_DATA=4'd1.
  - FSM encodings AR_IDLE/AR_BUSY.
  - AXI constants ARLEN_SINGLE=8'd0, ARBURST_INCR=2'b01.
- One sub-module rd_outst_cnt (inc, dec, full, empty; width $clog2(MAX_OUTST+1)), instantiated twice.

Test Plan:
- Reset release, inst_req=1, inst_addr=0x1C000000, arready=1 -> arvalid at cycle+1 with arid=0, araddr=0x1C000000; inst_addr_ok same cycle; R (rid=0, rdata=0x02800000) -> inst_data_ok=1, inst_rdata=0x02800000.
- inst_req and data_req both asserted, data_addr=0x1000 -> data granted first (arid=1); inst granted on the next AR_IDLE.
- wr_pending=1, wr_pending_addr=0x1004, data_addr=0x1006, inst_req=1 -> inst granted, data blocked. Then wr_pending=0 -> data granted with araddr=0x1006.
- MAX_OUTST=2: two inst ARs accepted with no R returned, third inst_req -> no arvalid. rvalid with rid=0 -> inst_cnt=1 and the third request is granted.
- data_req held, inst_req held, STARVE_LIMIT=4, arready=1 -> four data grants, then fifth grant is arid=0.
- arready=0 for 5 cycles with arvalid=1, aresetn pulsed low mid-hold -> arvalid=0 immediately (async) and counters=0.

Source files
------------

// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI read-path constants, ARID map and AR FSM encoding.
// Rev 1.0
`default_nettype none

package axi_pkg;

  localparam logic [3:0] ARID_INST    = 4'd0;
  localparam logic [3:0] ARID_DATA    = 4'd1;

  localparam logic [7:0] ARLEN_SINGLE = 8'd0;
  localparam logic [1:0] ARBURST_INCR = 2'b01;

  typedef enum logic [0:0] {
    AR_IDLE = 1'b0,
    AR_BUSY = 1'b1
  } ar_state_t;

  // Word-granular overlap between a pending write and a read address.
  function automatic logic raw_hazard(input logic        wr_pend,
                                      input logic [29:0] wr_word,
                                      input logic [29:0] rd_word);
    return wr_pend && (wr_word == rd_word);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rd_outst_cnt.sv
// rd_outst_cnt: saturating outstanding-read counter for one AXI requester.
// Rev 1.0
`default_nettype none

module rd_outst_cnt
  import axi_pkg::*;
#(
  parameter int MAX_OUTST = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  logic [CNT_W-1:0] cnt;

  // A decrement with nothing outstanding is dropped rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign full  = (cnt == CNT_W'(MAX_OUTST));
  assign empty = (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: single-beat AXI AR/R arbiter for fetch and load ports.
// Rev 1.0
`default_nettype none

module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter int MAX_OUTST    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        aclk,
  input  logic        aresetn,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic [1:0]  inst_size,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [1:0]  data_size,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  input  logic        wr_pending,
  input  logic [31:0] wr_pending_addr,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready
);

  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  if (MAX_OUTST < 1 || MAX_OUTST > 7) begin : g_bad_max_outst
    $error("axi_rd_arbiter: MAX_OUTST must be in 1..7");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
    $error("axi_rd_arbiter: STARVE_LIMIT must be at least 1");
  end

  ar_state_t        state;
  logic [STV_W-1:0] starve_cnt;

  logic inst_full, inst_empty;
  logic data_full, data_empty;

  logic ar_hs, r_hs;
  logic inst_ar_hs, data_ar_hs;
  logic inst_r_hs, data_r_hs;
  logic raw_block, starved;
  logic inst_go, data_go, pick_inst;
  logic unused_wr_byte_bits;

  assign ar_hs      = arvalid && arready;
  assign r_hs       = rvalid && rready;
  assign inst_ar_hs = ar_hs && (arid == ARID_INST);
  assign data_ar_hs = ar_hs && (arid == ARID_DATA);
  assign inst_r_hs  = r_hs && (rid == ARID_INST);
  assign data_r_hs  = r_hs && (rid == ARID_DATA);

  assign raw_block  = raw_hazard(wr_pending, wr_pending_addr[31:2], data_addr[31:2]);
  assign starved    = (starve_cnt == STV_W'(STARVE_LIMIT));
  assign data_go    = data_req && !data_full && !raw_block;
  assign inst_go    = inst_req && !inst_full;
  // Data normally wins; a starved fetch, or a blocked/idle load, lets inst through.
  assign pick_inst  = inst_go && (starved || !data_go);

  assign unused_wr_byte_bits = ^wr_pending_addr[1:0];

  assign inst_addr_ok = inst_ar_hs;
  assign data_addr_ok = data_ar_hs;
  assign inst_data_ok = inst_r_hs;
  assign data_data_ok = data_r_hs;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= AR_IDLE;
      arvalid <= 1'b0;
      arid    <= '0;
      araddr  <= '0;
      arsize  <= '0;
      rready  <= 1'b0;
    end else begin
      rready <= 1'b1;
      case (state)
        AR_IDLE: begin
          if (inst_go || data_go) begin
            arvalid <= 1'b1;
            state   <= AR_BUSY;
            if (pick_inst) begin
              arid   <= ARID_INST;
              araddr <= inst_addr;
              arsize <= {1'b0, inst_size};
            end else begin
              arid   <= ARID_DATA;
              araddr <= data_addr;
              arsize <= {1'b0, data_size};
            end
          end
        end
        AR_BUSY: begin
          if (arready) begin
            arvalid <= 1'b0;
            state   <= AR_IDLE;
          end
        end
        default: begin
          arvalid <= 1'b0;
          state   <= AR_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      starve_cnt <= '0;
    end else if (!inst_req || inst_ar_hs) begin
      starve_cnt <= '0;
    end else if (data_ar_hs && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  rd_outst_cnt #(
    .MAX_OUTST (MAX_OUTST)
  ) u_inst_cnt (
    .clk   (aclk),
    .rst_n (aresetn),
    .inc   (inst_ar_hs),
    .dec   (inst_r_hs),
    .full  (inst_full),
    .empty (inst_empty)
  );

  rd_outst_cnt #(
    .MAX_OUTST (MAX_OUTST)
  ) u_data_cnt (
    .clk   (aclk),
    .rst_n (aresetn),
    .inc   (data_ar_hs),
    .dec   (data_r_hs),
    .full  (data_full),
    .empty (data_empty)
  );

  a_rid_known: assert property (@(posedge aclk) disable iff (!aresetn)
    r_hs |-> (rid <= ARID_DATA));
  a_inst_no_underflow: assert property (@(posedge aclk) disable iff (!aresetn)
    !(inst_r_hs && inst_empty));
  a_data_no_underflow: assert property (@(posedge aclk) disable iff (!aresetn)
    !(data_r_hs && data_empty));

endmodule

`default_nettype wire
